// File: rtl/scratch_pad_pkg.sv
// rtl/scratch_pad_pkg.sv - shared scratch-pad widths, clog2 helper and response entry layout
package scratch_pad_pkg;

    localparam int SP_WIDTH      = 64;
    localparam int SP_ADDR_WIDTH = 8;

    // Smallest n with 2**n >= value; pointer width for power-of-2 depths.
    function automatic int sp_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic {
        SP_RSP_READ  = 1'b0,
        SP_RSP_WRITE = 1'b1
    } sp_rsp_kind_e;

    typedef struct packed {
        sp_rsp_kind_e          kind;
        logic [SP_WIDTH-1:0]   data;
    } sp_rsp_entry_t;

endpackage

// File: rtl/sp_rsp_fifo.sv
// rtl/sp_rsp_fifo.sv - response buffer: DEPTH x WIDTH synchronous FIFO with wrapping pointers
module sp_rsp_fifo
    import scratch_pad_pkg::*;
#(
    parameter int WIDTH = SP_WIDTH,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage array carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy including the full state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is shown only when occupied so an empty buffer presents zero.
    always_comb begin
        pop_data = '0;
        if (count != '0) begin
            pop_data = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/scratch_pad_client.sv
// rtl/scratch_pad_client.sv - scratch-pad RAM initiator; SCRATCH_PAD_WR_ACK_EN adds write responses
module scratch_pad_client
    import scratch_pad_pkg::*;
#(
    parameter int WIDTH      = SP_WIDTH,
    parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    output logic                  ram_wr_en,
    output logic [WIDTH-1:0]      ram_d,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]      ram_q,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data
);

    localparam int PTR_W = sp_clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             accept;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   committed;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    // Credit counts buffered entries plus the one whose RAM data lands next edge;
    // both are registers, so the consumer side never reaches req_ready combinationally.
    assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign req_ready = ~rst & (committed < (CNT_W+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;

    assign ram_addr  = req_addr;
    assign ram_d     = req_data;
    assign ram_wr_en = accept & req_wr;

`ifdef SCRATCH_PAD_WR_ACK_EN
    sp_rsp_kind_e     kind_q;
    logic [WIDTH-1:0] wr_data_q;

    // Every accept reserves a slot; writes echo their own data one edge later, keeping order with reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight  <= 1'b0;
            kind_q    <= SP_RSP_READ;
            wr_data_q <= '0;
        end else begin
            inflight  <= accept;
            kind_q    <= req_wr ? SP_RSP_WRITE : SP_RSP_READ;
            wr_data_q <= req_data;
        end
    end

    assign push_data = (kind_q == SP_RSP_WRITE) ? wr_data_q : ram_q;
`else
    // Only reads reserve a slot; the RAM returns their data one edge after the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept & ~req_wr;
        end
    end

    assign push_data = ram_q;
`endif

    assign push      = inflight;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    sp_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH),
        .PTR_W (PTR_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (rsp_data),
        .count     (count)
    );

endmodule

// File: tb/tb_scratch_pad_client.sv
// tb/tb_scratch_pad_client.sv - self-checking bench for scratch_pad_client with a behavioural RAM
module tb_scratch_pad_client;

    localparam int DEPTH = 4;

`ifdef SCRATCH_PAD_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic        ram_wr_en;
    logic [63:0] ram_d;
    logic [7:0]  ram_addr;
    logic [63:0] ram_q;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;

    always #5 clk = ~clk;

    scratch_pad_client #(
        .WIDTH      (64),
        .ADDR_WIDTH (8),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ram_wr_en (ram_wr_en),
        .ram_d     (ram_d),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    // Scratch-pad RAM bank: registered q, one-cycle read.
    logic [63:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr] <= ram_d;
        ram_q <= ram_mem[ram_addr];
    end

    // Reference model: memory image plus an ordered list of owed responses with their due cycle.
    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        model_q[$];
    logic [63:0] shadow [256];
    int          cyc;
    int          n_acc;
    int          n_pops;
    logic [63:0] last_pop_data;
    logic        last_accepted;
    int          tests;
    int          fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model past the edge.
    task automatic step(input logic v, input logic w, input logic [7:0] a,
                        input logic [63:0] d, input logic rr);
        logic exp_valid;
        logic exp_ready;
        exp_t e;
        req_valid = v; req_wr = w; req_addr = a; req_data = d; rsp_ready = rr;
        #1;
        exp_valid = (model_q.size() > 0) && (model_q[0].due <= cyc);
        exp_ready = (model_q.size() < DEPTH);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid) check("rsp_data", rsp_data, model_q[0].data);
        last_accepted = v && exp_ready;
        check("ram_wr_en", 64'(ram_wr_en), 64'(last_accepted && w));
        if (last_accepted) check("ram_addr", 64'(ram_addr), 64'(a));
        if (last_accepted && w) check("ram_d", ram_d, d);
        if (exp_valid && rr) begin
            e = model_q.pop_front();
            last_pop_data = e.data;
            n_pops++;
        end
        if (last_accepted) begin
            n_acc++;
            if (w) begin
                shadow[a] = d;
                if (WR_ACK) model_q.push_back('{data: d, due: cyc + 2});
            end else begin
                model_q.push_back('{data: shadow[a], due: cyc + 2});
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && model_q.size() != 0; i++) step(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
        if (model_q.size() != 0) check("drain_timeout", 64'(model_q.size()), 64'd0);
        #1;
        check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    // Raise reset between edges, check outputs drop at once, hold across two edges, release.
    task automatic reset_check(input string tag);
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_data = '1; rsp_ready = 1'b1;
        #1;
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  rsp_data,       64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_ram_wr_en"}, 64'(ram_wr_en), 64'd0);
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        check({tag, "_held_valid"}, 64'(rsp_valid), 64'd0);
        rst = 1'b0; req_valid = 1'b0;
        cyc += 2;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; n_acc = 0; n_pops = 0; last_pop_data = '0;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
        @(negedge clk);
        reset_check("reset");

        // Fill the whole RAM with known random data.
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), {$urandom, $urandom}, 1'b1);
        drain();

        // 1: write then read 0x10; model enforces the 2-edge latency.
        step(1'b1, 1'b1, 8'h10, 64'hDEAD_BEEF, 1'b1);
        step(1'b1, 1'b0, 8'h10, 64'd0, 1'b1);
        drain();
        check("t1_data", last_pop_data, 64'hDEAD_BEEF);

        // 2: read right after write to the same address.
        step(1'b1, 1'b1, 8'h20, 64'hA, 1'b1);
        step(1'b1, 1'b0, 8'h20, 64'd0, 1'b1);
        drain();
        check("t2_data", last_pop_data, 64'hA);

        // 3: credit limit with the consumer stalled.
        n_acc = 0; n_pops = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(i), 64'd0, 1'b0);
        check("t3_accepts", 64'(n_acc), 64'd4);
        #1;
        check("t3_ready_low", 64'(req_ready), 64'd0);
        for (int r = 4; r < 6; r++) begin
            last_accepted = 1'b0;
            for (int k = 0; k < 10 && !last_accepted; k++) step(1'b1, 1'b0, 8'(r), 64'd0, 1'b1);
        end
        drain();
        check("t3_total_accepts", 64'(n_acc), 64'd6);
        check("t3_pops", 64'(n_pops), 64'd6);

        // 4: full address sweep, one accept per cycle.
        n_acc = 0; n_pops = 0;
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 8'(i), 64'd0, 1'b1);
        check("t4_accepts", 64'(n_acc), 64'd256);
        drain();
        check("t4_pops", 64'(n_pops), 64'd256);

        // 5: reset with one read in flight and three buffered.
        n_acc = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 64'd0, 1'b0);
        check("t5_accepts", 64'(n_acc), 64'd4);
        #1;
        check("t5_pre_valid", 64'(rsp_valid), 64'd1);
        reset_check("t5");
        step(1'b1, 1'b0, 8'h10, 64'd0, 1'b1);
        drain();
        check("t5_data", last_pop_data, 64'hDEAD_BEEF);

        // 6: write ack configuration decides the response count.
        n_pops = 0;
        step(1'b1, 1'b1, 8'h03, 64'h5, 1'b1);
        step(1'b1, 1'b0, 8'h03, 64'd0, 1'b1);
        drain();
        check("t6_pops", 64'(n_pops), WR_ACK ? 64'd2 : 64'd1);
        check("t6_data", last_pop_data, 64'h5);

        // Random traffic on a small address window with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom % 16),
                 {$urandom, $urandom}, ($urandom % 4) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
